// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in, serial-out serializer.
package serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // Even parity: the appended bit makes the frame's total count of ones even.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle between a word source (master) and the serializer (slave).
interface piso_serializer_if
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_last, busy
  );

endinterface

// File: rtl/piso_serializer.sv
// Serializes WIDTH-bit words onto a continuous one-bit stream, optionally
// followed by an even-parity bit, with zero-gap back-to-back frames.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,  // legal range 2..32
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input logic             clk,
  input logic             reset,
  piso_serializer_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SHIFT  = SHIFT;
  localparam logic [1:0] S_PARITY = PARITY;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             ser_last_q;
  logic             parity_q;
  logic             accept;

  // Ready while idle or while the final bit of a frame is on the wire, so the
  // next word can start on the very next cycle.
  assign bus.in_ready  = reset && ((state == S_IDLE) || ser_last_q);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.busy      = (state != S_IDLE);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values that existed before this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the shift register is a handful of flops rather than a memory,
      // so it is cleared along with the control state.
      state       <= S_IDLE;
      shreg       <= '0;
      cnt         <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      parity_q    <= 1'b0;
    end else if (accept) begin
      state       <= S_SHIFT;
      shreg       <= bus.in_data;
      cnt         <= '0;
      parity_q    <= even_parity(MAX_WIDTH'(bus.in_data));
      ser_out_q   <= LSB_FIRST ? bus.in_data[0] : bus.in_data[WIDTH-1];
      ser_valid_q <= 1'b1;
      ser_last_q  <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          if (cnt == LAST_IDX) begin
            if (PARITY_EN) begin
              state      <= S_PARITY;
              ser_out_q  <= parity_q;
              ser_last_q <= 1'b1;
            end else begin
              state       <= S_IDLE;
              ser_out_q   <= 1'b0;
              ser_valid_q <= 1'b0;
              ser_last_q  <= 1'b0;
            end
          end else begin
            // The bit on the wire always sits at the outgoing end of shreg.
            shreg      <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
            ser_out_q  <= LSB_FIRST ? shreg[1] : shreg[WIDTH-2];
            cnt        <= cnt + 1'b1;
            ser_last_q <= !PARITY_EN && ((cnt + 1'b1) == LAST_IDX);
          end
        end
        default: begin
          state       <= S_IDLE;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          ser_last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: three serializer configurations, each feeding a one-bit
// register whose output is reassembled and compared against the sent words.
module tb_piso_serializer;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] din [3];
  logic       vld [3];
  wire        rdy [3];
  wire        so  [3];
  wire        sv  [3];
  wire        sl  [3];
  wire        bz  [3];
  wire        qv  [3];

  // Instance 0: LSB first, no parity. 1: MSB first. 2: LSB first with parity.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    piso_serializer_if #(.WIDTH(8)) bus ();
    logic q_r;

    assign bus.in_data  = din[g];
    assign bus.in_valid = vld[g];
    assign rdy[g]       = bus.in_ready;
    assign so[g]        = bus.ser_out;
    assign sv[g]        = bus.ser_valid;
    assign sl[g]        = bus.ser_last;
    assign bz[g]        = bus.busy;
    assign qv[g]        = q_r;

    piso_serializer #(
      .WIDTH    (8),
      .LSB_FIRST(g == 1 ? 1'b0 : 1'b1),
      .PARITY_EN(g == 2 ? 1'b1 : 1'b0)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
    );

    // Downstream flip-flop: q is ser_out delayed by one cycle.
    always @(posedge clk) q_r <= bus.ser_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din[k] = 8'h00;
      vld[k] = 1'b0;
    end
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({sv[k], so[k], sl[k], bz[k], rdy[k]} !== 5'b00000) begin
        failures++;
        $display("FAIL reset_outputs[%0d] got=%b exp=00000", k,
                 {sv[k], so[k], sl[k], bz[k], rdy[k]});
      end
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy[k] !== 1'b1) begin
        failures++;
        $display("FAIL reset_ready[%0d] got=%b exp=1", k, rdy[k]);
      end
    end
  endtask

  // One isolated frame; exp[i] is the bit expected on ser_out in cycle i.
  task automatic run_frame(input int k, input logic [7:0] word, input int n,
                           input logic [8:0] exp, input string name);
    logic [8:0] rx   = '0;
    logic       prev = 1'b0;
    din[k] = word;
    vld[k] = 1'b1;
    step();
    vld[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (so[k] !== exp[i]) begin
        failures++;
        $display("FAIL %s_ser_out[%0d] got=%b exp=%b", name, i, so[k], exp[i]);
      end
      checks++;
      if (sv[k] !== 1'b1) begin
        failures++;
        $display("FAIL %s_ser_valid[%0d] got=%b exp=1", name, i, sv[k]);
      end
      checks++;
      if (sl[k] !== (i == n - 1)) begin
        failures++;
        $display("FAIL %s_ser_last[%0d] got=%b exp=%b", name, i, sl[k], (i == n - 1));
      end
      checks++;
      if (rdy[k] !== (i == n - 1)) begin
        failures++;
        $display("FAIL %s_in_ready[%0d] got=%b exp=%b", name, i, rdy[k], (i == n - 1));
      end
      checks++;
      if (qv[k] !== prev) begin
        failures++;
        $display("FAIL %s_q[%0d] got=%b exp=%b", name, i, qv[k], prev);
      end
      if (i > 0) rx[i-1] = qv[k];
      prev = exp[i];
      step();
    end
    rx[n-1] = qv[k];
    checks++;
    if ({sv[k], bz[k]} !== 2'b00) begin
      failures++;
      $display("FAIL %s_idle_after got=%b exp=00", name, {sv[k], bz[k]});
    end
    checks++;
    if (rx !== exp) begin
      failures++;
      $display("FAIL %s_q_word got=%h exp=%h", name, rx, exp);
    end
  endtask

  task automatic test_lsb_first();
    run_frame(0, 8'hA5, 8, 9'h0A5, "lsb_a5");
  endtask

  task automatic test_msb_first();
    run_frame(1, 8'hA5, 8, 9'h0A5, "msb_a5");
    run_frame(1, 8'h01, 8, 9'h080, "msb_01");
  endtask

  task automatic test_parity();
    run_frame(2, 8'h07, 9, 9'h107, "par_07");
    run_frame(2, 8'h03, 9, 9'h003, "par_03");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp  = 16'h8001;
    logic        prev = 1'b0;
    din[0] = 8'h01;
    vld[0] = 1'b1;
    step();
    din[0] = 8'h80;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) vld[0] = 1'b0;
      checks++;
      if (so[0] !== exp[i]) begin
        failures++;
        $display("FAIL b2b_ser_out[%0d] got=%b exp=%b", i, so[0], exp[i]);
      end
      checks++;
      if (sv[0] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ser_valid[%0d] got=%b exp=1", i, sv[0]);
      end
      checks++;
      if (sl[0] !== (i == 7 || i == 15)) begin
        failures++;
        $display("FAIL b2b_ser_last[%0d] got=%b exp=%b", i, sl[0], (i == 7 || i == 15));
      end
      checks++;
      if (rdy[0] !== (i == 7 || i == 15)) begin
        failures++;
        $display("FAIL b2b_in_ready[%0d] got=%b exp=%b", i, rdy[0], (i == 7 || i == 15));
      end
      checks++;
      if (qv[0] !== prev) begin
        failures++;
        $display("FAIL b2b_q[%0d] got=%b exp=%b", i, qv[0], prev);
      end
      prev = exp[i];
      step();
    end
    checks++;
    if (sv[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_valid_after got=%b exp=0", sv[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp = 8'h55;
    din[0] = 8'h00;
    vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        din[0] = 8'h55;
        vld[0] = 1'b1;
      end
      checks++;
      if ({so[0], sv[0]} !== 2'b01) begin
        failures++;
        $display("FAIL bp_first_frame[%0d] got=%b exp=01", i, {so[0], sv[0]});
      end
      if (i >= 3) begin
        checks++;
        if ({rdy[0], bz[0]} !== {(i == 7), 1'b1}) begin
          failures++;
          $display("FAIL bp_ready_busy[%0d] got=%b exp=%b", i, {rdy[0], bz[0]}, {(i == 7), 1'b1});
        end
      end
      step();
    end
    vld[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({so[0], sv[0], sl[0]} !== {exp[i], 1'b1, (i == 7)}) begin
        failures++;
        $display("FAIL bp_second_frame[%0d] got=%b exp=%b", i, {so[0], sv[0], sl[0]},
                 {exp[i], 1'b1, (i == 7)});
      end
      step();
    end
    checks++;
    if (sv[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_valid_after got=%b exp=0", sv[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    din[0] = 8'hFF;
    vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    step();
    step();
    step();
    checks++;
    if ({so[0], sv[0]} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_bit3 got=%b exp=11", {so[0], sv[0]});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({sv[0], bz[0], so[0], sl[0], rdy[0]} !== 5'b00000) begin
      failures++;
      $display("FAIL rst_mid_cleared got=%b exp=00000", {sv[0], bz[0], so[0], sl[0], rdy[0]});
    end
    checks++;
    if (qv[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_q_bit3 got=%b exp=1", qv[0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_ready got=%b exp=1", rdy[0]);
    end
    step();
    checks++;
    if (qv[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_q_cleared got=%b exp=0", qv[0]);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({sv[0], so[0]} !== 2'b00) begin
        failures++;
        $display("FAIL rst_mid_no_bits[%0d] got=%b exp=00", i, {sv[0], so[0]});
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_parity();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
